// File: rtl/sme_pkg.sv
// Shared definitions for the string-match engine and its host driver.
package sme_pkg;

  localparam int STR_MAX = 32;
  localparam int PAT_MAX = 8;
  localparam int CHAR_W  = 8;

  typedef logic [CHAR_W-1:0] char_t;

  // Host driver FSM encoding
  typedef logic [2:0] state_t;
  localparam state_t ST_IDLE     = 3'd0;
  localparam state_t ST_SEND_STR = 3'd1;
  localparam state_t ST_SEND_PAT = 3'd2;
  localparam state_t ST_WAIT     = 3'd3;
  localparam state_t ST_FIN      = 3'd4;

  // Pattern metacharacters understood by the engine
  localparam char_t CARET  = 8'h5E;
  localparam char_t DOLLAR = 8'h24;
  localparam char_t DOT    = 8'h2E;
  localparam char_t STAR   = 8'h2A;
  localparam char_t SPACE  = 8'h20;

  // Length is usable when it is in 1..lim
  function automatic logic len_ok(input int len, input int lim);
    return (len >= 1) && (len <= lim);
  endfunction

endpackage

// File: rtl/sme_host_driver_if.sv
// Character stream / result bus between host driver (master) and match engine (slave).
interface sme_host_driver_if;
  import sme_pkg::*;

  char_t      chardata;
  logic       isstring;
  logic       ispattern;
  logic       valid;
  logic       match;
  logic [4:0] match_index;

  modport master (output chardata, isstring, ispattern,
                  input  valid, match, match_index);
  modport slave  (input  chardata, isstring, ispattern,
                  output valid, match, match_index);
endinterface

// File: rtl/sme_char_buf.sv
// Character buffer: synchronous write, combinational read. Contents are not reset.
module sme_char_buf
  import sme_pkg::*;
#(
  parameter int DEPTH = 32,
  parameter int W     = CHAR_W,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem [DEPTH];

  // Host write port
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/sme_host_driver.sv
// Initiator side of the string-match engine: streams the buffered string and
// pattern to the engine, waits for its verdict and keeps it in result registers.
module sme_host_driver #(
  parameter int STR_MAX = sme_pkg::STR_MAX,
  parameter int PAT_MAX = sme_pkg::PAT_MAX,
  parameter int TIMEOUT = 1023
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       wr_en,
  input  logic       wr_sel,
  input  logic [4:0] wr_addr,
  input  logic [7:0] wr_data,
  input  logic [5:0] str_len,
  input  logic [3:0] pat_len,
  input  logic       keep_string,
  input  logic       start,
  output logic       busy,
  output logic       done,
  output logic       cfg_err,
  output logic       timeout_err,
  output logic       result_match,
  output logic [4:0] result_index,
  sme_host_driver_if.master eng
);
  import sme_pkg::*;

  localparam int SAW = $clog2(STR_MAX);
  localparam int PAW = $clog2(PAT_MAX);
  localparam int WW  = $clog2(TIMEOUT + 1);
  // Last count before expiry: the abort lands exactly TIMEOUT cycles after WAIT entry
  localparam logic [WW-1:0] W_LAST = WW'(TIMEOUT - 1);

  state_t          state;
  logic [5:0]      sidx, str_len_q;
  logic [3:0]      pidx, pat_len_q;
  logic [WW-1:0]   wcnt;
  char_t           chardata_q;
  logic            isstring_q, ispattern_q;

  logic            str_we, pat_we, start_ok;
  logic [SAW-1:0]  str_raddr;
  logic [PAW-1:0]  pat_raddr;
  char_t           str_rdata, pat_rdata;

  // Buffers are frozen while a transaction is in flight; out-of-range writes drop
  assign str_we = wr_en && !busy && !wr_sel && (int'(wr_addr) < STR_MAX);
  assign pat_we = wr_en && !busy &&  wr_sel && (int'(wr_addr) < PAT_MAX);

  assign start_ok = len_ok(int'(pat_len), PAT_MAX) &&
                    (keep_string || len_ok(int'(str_len), STR_MAX));

  sme_char_buf #(.DEPTH(STR_MAX), .W(CHAR_W)) u_str_buf (
    .clk   (clk),
    .we    (str_we),
    .waddr (wr_addr[SAW-1:0]),
    .wdata (wr_data),
    .raddr (str_raddr),
    .rdata (str_rdata)
  );

  sme_char_buf #(.DEPTH(PAT_MAX), .W(CHAR_W)) u_pat_buf (
    .clk   (clk),
    .we    (pat_we),
    .waddr (wr_addr[PAW-1:0]),
    .wdata (wr_data),
    .raddr (pat_raddr),
    .rdata (pat_rdata)
  );

  // Look one char ahead so the registered outputs carry the next char; index 0 otherwise
  always_comb begin
    str_raddr = '0;
    pat_raddr = '0;
    if (state == ST_SEND_STR) str_raddr = SAW'(sidx + 6'd1);
    if (state == ST_SEND_PAT) pat_raddr = PAW'(pidx + 4'd1);
  end

  // Transaction FSM; every engine-facing and host-facing output is a flop
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= ST_IDLE;
      sidx         <= '0;
      pidx         <= '0;
      wcnt         <= '0;
      str_len_q    <= '0;
      pat_len_q    <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      cfg_err      <= 1'b0;
      timeout_err  <= 1'b0;
      result_match <= 1'b0;
      result_index <= '0;
      chardata_q   <= '0;
      isstring_q   <= 1'b0;
      ispattern_q  <= 1'b0;
    end else begin
      done        <= 1'b0;
      cfg_err     <= 1'b0;
      timeout_err <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            if (!start_ok) begin
              cfg_err <= 1'b1;
            end else begin
              busy      <= 1'b1;
              str_len_q <= str_len;
              pat_len_q <= pat_len;
              sidx      <= '0;
              pidx      <= '0;
              if (keep_string) begin
                state       <= ST_SEND_PAT;
                ispattern_q <= 1'b1;
                chardata_q  <= pat_rdata;
              end else begin
                state      <= ST_SEND_STR;
                isstring_q <= 1'b1;
                chardata_q <= str_rdata;
              end
            end
          end
        end
        ST_SEND_STR: begin
          if (sidx == str_len_q - 6'd1) begin
            state       <= ST_SEND_PAT;
            isstring_q  <= 1'b0;
            ispattern_q <= 1'b1;
            chardata_q  <= pat_rdata;
            pidx        <= '0;
          end else begin
            sidx       <= sidx + 6'd1;
            chardata_q <= str_rdata;
          end
        end
        ST_SEND_PAT: begin
          if (pidx == pat_len_q - 4'd1) begin
            state       <= ST_WAIT;
            ispattern_q <= 1'b0;
            chardata_q  <= '0;
            wcnt        <= '0;
          end else begin
            pidx       <= pidx + 4'd1;
            chardata_q <= pat_rdata;
          end
        end
        ST_WAIT: begin
          if (eng.valid) begin
            result_match <= eng.match;
            result_index <= eng.match_index;
            done         <= 1'b1;
            busy         <= 1'b0;
            state        <= ST_FIN;
          end else if (wcnt == W_LAST) begin
            timeout_err <= 1'b1;
            busy        <= 1'b0;
            state       <= ST_IDLE;
          end else begin
            wcnt <= wcnt + WW'(1);
          end
        end
        // done is high here; start is taken from the following cycle
        ST_FIN:  state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign eng.chardata  = chardata_q;
  assign eng.isstring  = isstring_q;
  assign eng.ispattern = ispattern_q;

endmodule

// File: tb/tb_sme_host_driver.sv
// Bench for sme_host_driver: directed table, corner sequences, random transactions.
module tb_sme_host_driver;
  import sme_pkg::*;

  localparam int TO = 1023;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       wr_en = 1'b0, wr_sel = 1'b0;
  logic [4:0] wr_addr = '0;
  logic [7:0] wr_data = '0;
  logic [5:0] str_len = '0;
  logic [3:0] pat_len = '0;
  logic       keep_string = 1'b0, start = 1'b0;
  logic       busy, done, cfg_err, timeout_err, result_match;
  logic [4:0] result_index;

  sme_host_driver_if eng_if();

  sme_host_driver #(.STR_MAX(STR_MAX), .PAT_MAX(PAT_MAX), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_sel(wr_sel), .wr_addr(wr_addr),
    .wr_data(wr_data), .str_len(str_len), .pat_len(pat_len), .keep_string(keep_string),
    .start(start), .busy(busy), .done(done), .cfg_err(cfg_err), .timeout_err(timeout_err),
    .result_match(result_match), .result_index(result_index), .eng(eng_if.master)
  );

  always #5 clk = ~clk;

  // Reference model: buffer images and last captured result
  logic [7:0] m_str [STR_MAX];
  logic [7:0] m_pat [PAT_MAX];
  logic       exp_rm;
  logic [4:0] exp_ri;
  int nvec = 0, nmis = 0;

  typedef struct {
    string s; string p;
    int slen, plen, ks, dly, vm, vi;
    int ecfg, erm, eri;
  } vec_t;
  vec_t tbl [9];

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s @%0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  task automatic host_write(input bit sel, input int addr, input logic [7:0] d);
    wr_en = 1'b1; wr_sel = sel; wr_addr = 5'(addr); wr_data = d;
    tick();
    wr_en = 1'b0;
    if (!sel) m_str[addr] = d;
    else if (addr < PAT_MAX) m_pat[addr] = d;
  endtask

  task automatic load_str(input string s);
    for (int i = 0; i < s.len(); i++) host_write(1'b0, i, s[i]);
  endtask

  task automatic load_pat(input string p);
    for (int i = 0; i < p.len(); i++) host_write(1'b1, i, p[i]);
  endtask

  // One transaction; dly < 0 means the engine never answers
  task automatic run_txn(input int slen, input int plen, input int ks, input int dly,
                         input bit vm, input logic [4:0] vi, input bit disturb,
                         output bit got_cfg);
    logic [8:0] q[$];
    bit bad;
    int n;
    bad = (plen < 1) || (plen > PAT_MAX) || ((ks == 0) && ((slen < 1) || (slen > STR_MAX)));
    str_len = 6'(slen); pat_len = 4'(plen); keep_string = (ks != 0); start = 1'b1;
    tick();
    start = 1'b0;
    got_cfg = cfg_err;
    if (bad) begin
      chk("cfg_reject", {busy, cfg_err, done, eng_if.isstring, eng_if.ispattern, eng_if.chardata},
          {1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00});
      tick();
      chk("cfg_clear", {busy, cfg_err, eng_if.isstring, eng_if.ispattern}, 4'b0000);
      return;
    end
    if (ks == 0) for (int i = 0; i < slen; i++) q.push_back({1'b1, m_str[i]});
    for (int j = 0; j < plen; j++) q.push_back({1'b0, m_pat[j]});
    for (int i = 0; i < q.size(); i++) begin
      chk($sformatf("stream[%0d]", i),
          {busy, done, eng_if.isstring, eng_if.ispattern, eng_if.chardata},
          {1'b1, 1'b0, q[i][8], ~q[i][8], q[i][7:0]});
      if (disturb) begin
        if (i == 0) begin
          start = 1'b1; str_len = 6'd1; pat_len = 4'd1; keep_string = 1'b0;
          wr_en = 1'b1; wr_sel = 1'b0; wr_addr = 5'd0; wr_data = 8'h7E;
        end
        if (i == 1) begin
          wr_en = 1'b1; wr_sel = 1'b1; wr_addr = 5'd0; wr_data = 8'h7E;
        end
        if (!q[i][8] && (i == 0 || q[i-1][8])) begin
          eng_if.valid = 1'b1; eng_if.match = ~vm; eng_if.match_index = ~vi;
        end
      end
      tick();
      start = 1'b0; wr_en = 1'b0; eng_if.valid = 1'b0;
    end
    chk("wait_entry", {busy, done, eng_if.isstring, eng_if.ispattern, eng_if.chardata,
                       result_match, result_index},
        {1'b1, 1'b0, 1'b0, 1'b0, 8'h00, exp_rm, exp_ri});
    if (dly >= 0) begin
      repeat (dly) tick();
      chk("wait_hold", {busy, done, timeout_err}, 3'b100);
      eng_if.valid = 1'b1; eng_if.match = vm; eng_if.match_index = vi;
      tick();
      eng_if.valid = 1'b0; eng_if.match = 1'($urandom); eng_if.match_index = 5'($urandom);
      exp_rm = vm; exp_ri = vi;
      chk("done_pulse", {busy, done, timeout_err, result_match, result_index},
          {1'b0, 1'b1, 1'b0, exp_rm, exp_ri});
      tick();
      chk("done_clear", {busy, done}, 2'b00);
    end else begin
      n = 0;
      do begin tick(); n++; end while (!timeout_err && n < TO + 5);
      chk("timeout_cycles", n, TO);
      chk("timeout_state", {busy, done, timeout_err, result_match, result_index},
          {1'b0, 1'b0, 1'b1, exp_rm, exp_ri});
      tick();
      chk("timeout_clear", {busy, timeout_err}, 2'b00);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1);
  end

  initial begin
    bit gc;
    int slen, plen;
    eng_if.valid = 1'b0; eng_if.match = 1'b0; eng_if.match_index = '0;
    exp_rm = 1'b0; exp_ri = '0;

    tbl[0] = '{"hello world", "o.l", 0, 3, 1, 0, 0, 3, 0, 0, 3};
    tbl[1] = '{"", "^wor", 11, 4, 0, 2, 1, 6, 0, 1, 6};
    tbl[2] = '{"", "", 11, 0, 0, 0, 0, 0, 1, 1, 6};
    tbl[3] = '{"", "", 33, 4, 0, 0, 0, 0, 1, 1, 6};
    tbl[4] = '{"", "", 11, 9, 0, 0, 0, 0, 1, 1, 6};
    tbl[5] = '{"", "", 0, 2, 0, 0, 0, 0, 1, 1, 6};
    tbl[6] = '{"", "", 40, 15, 1, 0, 0, 0, 1, 1, 6};
    tbl[7] = '{"abc$", "c$", 4, 2, 0, 5, 1, 2, 0, 1, 2};
    tbl[8] = '{"abcdefghijklmnopqrstuvwxyz012345", "a*b.c^$x", 32, 8, 0, 1, 1, 31, 0, 1, 31};

    repeat (3) @(posedge clk);
    #1;
    chk("reset_state", {busy, done, cfg_err, timeout_err, result_match, result_index,
                        eng_if.isstring, eng_if.ispattern, eng_if.chardata}, '0);
    reset = 1'b0;
    tick();

    for (int i = 0; i < STR_MAX; i++) host_write(1'b0, i, SPACE);
    for (int i = 0; i < PAT_MAX; i++) host_write(1'b1, i, SPACE);

    for (int k = 0; k < 9; k++) begin
      if (tbl[k].s.len() > 0) load_str(tbl[k].s);
      if (tbl[k].p.len() > 0) load_pat(tbl[k].p);
      run_txn(tbl[k].slen, tbl[k].plen, tbl[k].ks, tbl[k].dly,
              1'(tbl[k].vm), 5'(tbl[k].vi), 1'b0, gc);
      chk($sformatf("tbl[%0d].cfg", k), 32'(gc), 32'(tbl[k].ecfg));
      chk($sformatf("tbl[%0d].result", k), {result_match, result_index},
          {1'(tbl[k].erm), 5'(tbl[k].eri)});
    end

    // Engine silent: abort after TIMEOUT cycles, results kept
    load_str("hello world");
    load_pat("^wor");
    run_txn(11, 4, 0, -1, 1'b0, 5'd0, 1'b0, gc);

    // Writes, start and valid while busy must all be ignored
    run_txn(11, 4, 0, 0, 1'b0, 5'd17, 1'b1, gc);
    run_txn(11, 4, 0, 1, 1'b1, 5'd6, 1'b0, gc);

    // Pattern writes past the pattern depth are dropped
    host_write(1'b1, 9, "Q");
    host_write(1'b1, 12, "Z");
    run_txn(0, 4, 1, 0, 1'b1, 5'd1, 1'b0, gc);

    // Reset in the middle of the string phase
    str_len = 6'd11; pat_len = 4'd4; keep_string = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (5) tick();
    chk("pre_reset_char5", {busy, eng_if.isstring, eng_if.chardata}, {1'b1, 1'b1, m_str[5]});
    #2 reset = 1'b1;
    #1;
    chk("reset_async", {busy, done, cfg_err, timeout_err, result_match, result_index,
                        eng_if.isstring, eng_if.ispattern, eng_if.chardata}, '0);
    exp_rm = 1'b0; exp_ri = '0;
    #2 reset = 1'b0;
    tick();
    run_txn(11, 4, 0, 0, 1'b1, 5'd9, 1'b0, gc);

    // Random traffic
    for (int t = 0; t < 40; t++) begin
      repeat ($urandom_range(0, 4))
        host_write(1'($urandom), int'($urandom_range(0, 31)), 8'($urandom_range(32, 126)));
      if ($urandom_range(0, 9) == 0) slen = $urandom_range(0, 1) ? 0 : int'($urandom_range(33, 63));
      else slen = $urandom_range(1, STR_MAX);
      if ($urandom_range(0, 9) == 0) plen = $urandom_range(0, 1) ? 0 : int'($urandom_range(9, 15));
      else plen = $urandom_range(1, PAT_MAX);
      run_txn(slen, plen, ($urandom_range(0, 3) == 0) ? 1 : 0, int'($urandom_range(0, 6)),
              1'($urandom), 5'($urandom), (t % 8 == 3), gc);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
